// File: rtl/mont_arbiter_if.sv
// Request/response and multiplier-core bus for mont_arbiter.
//   req_valid/req_ready  : per-requester operand handshake (NREQ bits)
//   req_a/req_b/req_m    : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready  : per-requester result handshake (NREQ bits)
//   rsp_result/rsp_lat   : shared result and core latency of the last operation
//   mm_*                 : multiplier core start/read controls, operands, result, done
// slave  = arbiter view, master = requester/core environment view.
interface mont_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 381,
  parameter int unsigned LATW = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*W-1:0] req_m;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  logic [LATW-1:0]   rsp_lat;
  logic              mm_start;
  logic              mm_out_read;
  logic [W-1:0]      mm_a;
  logic [W-1:0]      mm_b;
  logic [W-1:0]      mm_m;
  logic [W-1:0]      mm_result;
  logic              mm_done;

  modport slave (
    input  req_valid, req_a, req_b, req_m, rsp_ready, mm_result, mm_done,
    output req_ready, rsp_valid, rsp_result, rsp_lat,
           mm_start, mm_out_read, mm_a, mm_b, mm_m
  );

  modport master (
    output req_valid, req_a, req_b, req_m, rsp_ready, mm_result, mm_done,
    input  req_ready, rsp_valid, rsp_result, rsp_lat,
           mm_start, mm_out_read, mm_a, mm_b, mm_m
  );
endinterface

// File: rtl/mont_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier core among NREQ requesters.
// One operation in flight: accept in IDLE, pre-load operands (LOAD), pulse start
// (START), count core cycles until done (BUSY), hold the result for the granted
// requester until it is accepted (RESP).
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset (shared with the core)
//   bus    : mont_arbiter_if.slave (request, response and core signals)
module mont_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 381,
  parameter int unsigned LATW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  mont_arbiter_if.slave bus
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]      state_q;
  logic [2:0]      state_d;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   grant_c;
  logic            found_c;
  logic            xfer_c;
  logic            done_c;
  logic            rsp_ack_c;
  logic            mm_start_c;
  logic            mm_out_read_c;
  logic [NREQ-1:0] req_ready_c;
  logic [NREQ-1:0] rsp_valid_c;
  logic [W-1:0]    sel_a_c;
  logic [W-1:0]    sel_b_c;
  logic [W-1:0]    sel_m_c;
  logic [W-1:0]    op_a_q;
  logic [W-1:0]    op_b_q;
  logic [W-1:0]    op_m_q;
  logic [W-1:0]    result_q;
  logic [LATW-1:0] lat_cnt_q;
  logic [LATW-1:0] lat_q;
  logic [LATW-1:0] lat_inc_c;
  int unsigned     idx_c;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    grant_c = '0;
    idx_c   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = 32'(rr_ptr_q) + k;
      if (idx_c >= NREQ) idx_c = idx_c - NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found_c && (j == idx_c) && bus.req_valid[j]) begin
          found_c = 1'b1;
          grant_c = GW'(j);
        end
      end
    end
  end

  assign xfer_c = (state_q == S_IDLE) && found_c;
  assign done_c = (state_q == S_BUSY) && bus.mm_done;

  // Operand mux for the requester being granted this cycle.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    sel_m_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (GW'(k) == grant_c) begin
        sel_a_c = bus.req_a[k*W +: W];
        sel_b_c = bus.req_b[k*W +: W];
        sel_m_c = bus.req_m[k*W +: W];
      end
    end
  end

  // Per-requester handshake decode; req_ready is masked while reset is asserted.
  always_comb begin
    req_ready_c = '0;
    rsp_valid_c = '0;
    rsp_ack_c   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_ready_c[k] = resetn && xfer_c && (GW'(k) == grant_c);
      rsp_valid_c[k] = (state_q == S_RESP) && (GW'(k) == grant_q);
      if (rsp_valid_c[k] && bus.rsp_ready[k]) rsp_ack_c = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and core control decode.
  always_comb begin
    state_d       = state_q;
    mm_start_c    = 1'b0;
    mm_out_read_c = 1'b0;
    case (state_q)
      S_IDLE:  if (xfer_c) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: begin
        mm_start_c = 1'b1;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        if (bus.mm_done) begin
          mm_out_read_c = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP:  if (rsp_ack_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating latency increment; the done cycle itself is counted.
  assign lat_inc_c = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LATW'(1);

  // Grant, operand capture, latency count, result capture and pointer advance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_m_q    <= '0;
      result_q  <= '0;
      lat_cnt_q <= '0;
      lat_q     <= '0;
    end else begin
      if (xfer_c) begin
        grant_q <= grant_c;
        op_a_q  <= sel_a_c;
        op_b_q  <= sel_b_c;
        op_m_q  <= sel_m_c;
      end
      if (state_q == S_START)     lat_cnt_q <= '0;
      else if (state_q == S_BUSY) lat_cnt_q <= lat_inc_c;
      if (done_c) begin
        result_q <= bus.mm_result;
        lat_q    <= lat_inc_c;
      end
      if (rsp_ack_c) rr_ptr_q <= (32'(grant_q) == NREQ - 1) ? '0 : grant_q + GW'(1);
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_lat     = lat_q;
  assign bus.mm_start    = mm_start_c;
  assign bus.mm_out_read = mm_out_read_c;
  assign bus.mm_a        = op_a_q;
  assign bus.mm_b        = op_b_q;
  assign bus.mm_m        = op_m_q;

endmodule
